md_unit: RTL and testbench
==========================

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port A, input, 32 bits: operand 1 (dividend, multiplicand, or mthi/mtlo data).
REQ-004 SHALL have port B, input, 32 bits: operand 2 (divisor, multiplier).
REQ-005 SHALL have port Op, input, 3 bits: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu.
REQ-006 SHALL have port Start, input, 1 bit: start Op this cycle, asserted for one cycle by the decode/execute stage.
REQ-007 SHALL have port Busy, output, 1 bit: registered; high while an operation is in flight.
REQ-008 SHALL have port HI, output, 32 bits: registered HI value.
REQ-009 SHALL have port LO, output, 32 bits: registered LO value.

Function
REQ-010 SHALL implement FSM states IDLE and RUN, with a down-counter cnt sized for DIV_CYCLES.
REQ-011 SHALL, in IDLE with Start=1 and Op in {0,1,2,3,6,7}, latch A, B and Op, load cnt with the op latency, enter RUN and set Busy=1 from the next cycle.
REQ-012 SHALL use latency MULT_CYCLES=5 for Op 0/1/6/7 and DIV_CYCLES=10 for Op 2/3, so Busy is high for exactly that many cycles.
REQ-013 SHALL, in RUN, decrement cnt each edge; on the edge where cnt==1, write HI/LO, clear Busy and return to IDLE, so new HI/LO are visible in the first cycle Busy is low.
REQ-014 SHALL compute mult as {HI,LO} = signed 64-bit A*B, and multu as the unsigned 64-bit A*B.
REQ-015 SHALL compute div as LO = quotient truncated toward zero and HI = remainder carrying the dividend's sign, both signed; divu SHALL give the unsigned quotient and remainder.
REQ-016 SHALL leave HI and LO unchanged on div/divu with B==0, while still holding Busy for DIV_CYCLES.
REQ-017 SHALL, in IDLE with Start=1 and Op=4 or Op=5, write A to HI or LO on that same edge, with zero latency and Busy staying 0.
REQ-018 SHALL ignore Start, with no state change, while Busy=1, including mthi/mtlo.
REQ-019 SHALL compute results from the latched operands only; A and B changing during RUN SHALL have no effect.

Reset
REQ-020 SHALL, on reset=1 at a clock edge, set HI=0, LO=0, Busy=0, cnt=0 and state IDLE.
REQ-021 SHALL let reset abort an in-flight operation with no HI/LO write, and SHALL give reset priority over Start on the same edge.

Configuration
REQ-022 SHALL, when macro MDU_MADD_EN is defined, implement Op 6 as {HI,LO} += signed A*B and Op 7 as {HI,LO} += unsigned A*B, both modulo 2^64 with latency MULT_CYCLES.
REQ-023 SHALL, when MDU_MADD_EN is undefined, treat Op 6/7 with Start as a no-op: no state change and Busy stays 0.

Structure
REQ-024 SHALL place Op encodings (MD_MULT..MD_MADDU) and MULT_CYCLES/DIV_CYCLES in the shared CPU constants package used by the controller.
REQ-025 SHALL keep the FSM, counter and arithmetic in the single module md_unit; no sub-module is required.
REQ-026 SHALL leave stall generation (Start | Busy when the decoded instruction is an MD-class instruction) to the hazard unit, not to md_unit.

Verification
REQ-027 SHALL test: mult with A=0xFFFFFFFF, B=2 -> Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-028 SHALL test: div with A=0xFFFFFFF9 (-7), B=2 -> Busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with A=7, B=2 -> LO=3, HI=1.
REQ-029 SHALL test: with HI=0x12, LO=0x34, div with B=0 -> Busy high for 10 cycles, then HI=0x12, LO=0x34 unchanged.
REQ-030 SHALL test: div started, then Start with mthi A=0xAA and Start with mult in cycles 2 and 4 of RUN -> both ignored, only the div result written.
REQ-031 SHALL test: reset asserted in cycle 3 of a div -> next cycle Busy=0, HI=0, LO=0; a later mult completes normally.
REQ-032 SHALL test, with MDU_MADD_EN defined: mtlo A=5, then madd A=2, B=3 -> after 5 cycles HI=0, LO=11; without the macro the same sequence -> LO=5 and Busy never rises.

Source files
------------

// File: rtl/md_unit_pkg.sv
// md_unit shared constants: op encodings, latencies, FSM state type.
// Imported by md_unit and by the controller that issues MD ops.
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  localparam logic [2:0] MD_MADD  = 3'd6;
  localparam logic [2:0] MD_MADDU = 3'd7;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
  localparam int CNT_W       = $clog2(DIV_CYCLES + 1);

  typedef enum logic {
    IDLE,
    RUN
  } md_state_t;

  function automatic logic is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mt(input logic [2:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

  function automatic logic is_madd(input logic [2:0] op);
    return (op == MD_MADD) || (op == MD_MADDU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Define MDU_MADD_EN to enable madd/maddu accumulation (Op 6/7).
module md_unit
  import md_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Op,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      la, la_n;
  logic [31:0]      lb, lb_n;
  logic [2:0]       lop, lop_n;
  logic [31:0]      hi_n, lo_n;
  logic             busy_n;

  logic             madd_ok;
  logic             go_mul, go_div, go_mt;

`ifdef MDU_MADD_EN
  assign madd_ok = 1'b1;
`else
  assign madd_ok = 1'b0;
`endif

  assign go_mul = is_mul(Op) || (madd_ok && is_madd(Op));
  assign go_div = is_div(Op);
  assign go_mt  = is_mt(Op);

  // Signed product via sign-extended operands, taken modulo 2^64.
  logic [63:0] ps, pu;
  assign ps = {{32{la[31]}}, la} * {{32{lb[31]}}, lb};
  assign pu = {32'd0, la} * {32'd0, lb};

  // Signed divide on magnitudes, then fix signs: truncation toward zero.
  logic [31:0] abs_a, abs_b, mq, mr, sq, sr, uq, ur;
  assign abs_a = la[31] ? 32'(0 - la) : la;
  assign abs_b = lb[31] ? 32'(0 - lb) : lb;
  assign mq    = abs_a / abs_b;
  assign mr    = abs_a % abs_b;
  assign sq    = (la[31] ^ lb[31]) ? 32'(0 - mq) : mq;
  assign sr    = la[31] ? 32'(0 - mr) : mr;
  assign uq    = la / lb;
  assign ur    = la % lb;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    busy_n  = Busy;
    hi_n    = HI;
    lo_n    = LO;
    la_n    = la;
    lb_n    = lb;
    lop_n   = lop;
    unique case (state)
      IDLE: begin
        if (Start) begin
          unique case (1'b1)
            go_mt: begin
              if (Op == MD_MTHI) hi_n = A;
              else               lo_n = A;
            end
            go_mul, go_div: begin
              la_n    = A;
              lb_n    = B;
              lop_n   = Op;
              cnt_n   = go_div ? CNT_W'(DIV_CYCLES)
                               : CNT_W'(MULT_CYCLES);
              busy_n  = 1'b1;
              state_n = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          busy_n  = 1'b0;
          state_n = IDLE;
          case (lop)
            MD_MULT:  {hi_n, lo_n} = ps;
            MD_MULTU: {hi_n, lo_n} = pu;
            MD_DIV:   if (lb != 32'd0) {hi_n, lo_n} = {sr, sq};
            MD_DIVU:  if (lb != 32'd0) {hi_n, lo_n} = {ur, uq};
`ifdef MDU_MADD_EN
            MD_MADD:  {hi_n, lo_n} = {HI, LO} + ps;
            MD_MADDU: {hi_n, lo_n} = {HI, LO} + pu;
`endif
            default: ;
          endcase
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      la    <= '0;
      lb    <= '0;
      lop   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      Busy  <= busy_n;
      HI    <= hi_n;
      LO    <= lo_n;
      la    <= la_n;
      lb    <= lb_n;
      lop   <= lop_n;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table plus scoreboard,
// with hand sequences for div-by-zero, ignored starts, reset abort, madd.
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  Op = '0;
  logic        Start = 1'b0;
  logic        Busy;
  logic [31:0] HI, LO;

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .Op    (Op),
    .Start (Start),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    Op    = op;
    A     = a;
    B     = b;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  // inject=1: try mthi in RUN cycle 2 and mult in RUN cycle 4.
  task automatic run(input string name, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input int cyc, input logic [31:0] hi,
                     input logic [31:0] lo, input bit inject);
    exp_t e;
    int   n;
    sb.push_back('{hi, lo, cyc});
    issue(op, a, b);
    n = 0;
    while (Busy && n < 64) begin
      n++;
      Start = 1'b0;
      if (inject && n == 2) begin
        Op = MD_MTHI; A = 32'hAA; Start = 1'b1;
      end else if (inject && n == 4) begin
        Op = MD_MULT; A = 32'd3; B = 32'd5; Start = 1'b1;
      end
      @(negedge clk);
    end
    Start = 1'b0;
    if (n >= 64) begin
      fails++;
      $display("FAIL %s busy_timeout: busy still high after %0d cycles", name, n);
    end
    e = sb.pop_front();
    chk({name, " busy_cycles"}, n, e.cyc);
    chk({name, " HI"}, HI, e.hi);
    chk({name, " LO"}, LO, e.lo);
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] a);
    issue(op, a, 32'd0);
    chk("mt busy", {31'd0, Busy}, 32'd0);
    if (op == MD_MTHI) chk("mthi HI", HI, a);
    else               chk("mtlo LO", LO, a);
  endtask

  initial begin
    vecs[0] = '{MD_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{MD_DIVU,  32'd7,        32'd2, 32'd1,        32'd3,        10};
    vecs[4] = '{MD_DIV,   32'd7, 32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[5] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 5};
    vecs[6] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 5};
    vecs[7] = '{MD_DIVU,  32'hFFFFFFFF, 32'h10, 32'hF,       32'h0FFFFFFF, 10};
    vecs[8] = '{MD_DIV,   32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFF2, 10};
    vecs[9] = '{MD_MULT,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset Busy", {31'd0, Busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);

    for (int i = 0; i < 10; i++)
      run($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
          vecs[i].cyc, vecs[i].hi, vecs[i].lo, 1'b0);

    mt(MD_MTHI, 32'h12);
    mt(MD_MTLO, 32'h34);
    run("div0", MD_DIV, 32'd5, 32'd0, 10, 32'h12, 32'h34, 1'b0);

    run("div_inject", MD_DIV, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b1);

    issue(MD_DIV, 32'd100, 32'd3);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort Busy", {31'd0, Busy}, 32'd0);
    chk("abort HI", HI, 32'd0);
    chk("abort LO", LO, 32'd0);
    run("post_reset_mult", MD_MULT, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b0);

    mt(MD_MTLO, 32'd5);
`ifdef MDU_MADD_EN
    run("madd", MD_MADD, 32'd2, 32'd3, 5, 32'd0, 32'd11, 1'b0);
    run("maddu", MD_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,
        32'hFFFFFFFE, 32'h0000000C, 1'b0);
`else
    run("madd", MD_MADD, 32'd2, 32'd3, 0, 32'd0, 32'd5, 1'b0);
    run("maddu", MD_MADDU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,
        32'd0, 32'd5, 1'b0);
    repeat (6) @(negedge clk);
    chk("madd idle Busy", {31'd0, Busy}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
